fsmind_handshake_ctrl: RTL and testbench
========================================

Name: fsmind_handshake_ctrl

Overview:
- FPGA-side initiator of the imager FSMIND handshake. The sensor, or its bench model, is the responder.
- Per pattern: raises FSMIND1, waits for FSMIND1ACK, holds for a programmed exposure, waits for FSMIND0, then acknowledges with FSMIND0ACK.
- Repeats for num_pat patterns per start command.
- Sits in Reveal_top between the wire-in registers (rst 0x10, exposure 0x11, num_pat 0x12) and the sensor pads.

Parameters:
- CNT_W, 32, width of exposure and num_pat inputs and of internal counters
- TIMEOUT_CYCLES, 1000000, clk cycles allowed in any sensor-wait state before error; 0 disables timeout
- SYNC_STAGES, 2, flip-flop synchronizer depth on FSMIND0 and FSMIND1ACK (min 2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse (trigger-in); begins a sequence when idle
- abort  in  1  level; forces return to IDLE from any state
- num_pat  in  CNT_W  patterns per sequence; latched on accepted start
- exposure  in  CNT_W  exposure length in clk cycles; latched on accepted start
- FSMIND0  in  1  sensor readout-ready indication (asynchronous)
- FSMIND1ACK  in  1  sensor acknowledge of FSMIND1 (asynchronous)
- FSMIND1  out  1  request to sensor, registered
- FSMIND0ACK  out  1  acknowledge of FSMIND0, registered
- busy  out  1  high in any state other than IDLE and ERR
- done  out  1  one-cycle pulse when the sequence completes
- error  out  1  sticky timeout flag
- pat_idx  out  CNT_W  index of the current pattern, 0-based

Behaviour:
- Reset values: state IDLE; FSMIND1=0, FSMIND0ACK=0, busy=0, done=0, error=0, pat_idx=0; synchronizer flops 0.
- Clock and reset: single clk domain; reset is asynchronous and active-high, named rst.
- Synchronizers: FSMIND0 and FSMIND1ACK pass through SYNC_STAGES flops. The FSM sees only the synchronized copies (f0_s, f1a_s), so input-to-FSM latency is SYNC_STAGES cycles.
- Outputs are registered and change on the cycle after the state transition.
- State IDLE:
  - start with num_pat==0: done pulses on the next cycle; stay IDLE.
  - start with num_pat!=0: latch num_pat and exposure, set pat_idx=0, go to REQ.
  - start while not IDLE is ignored.
- State REQ: FSMIND1=1. f1a_s=1 goes to EXPOSE with exp_cnt=0.
- State EXPOSE:
  - FSMIND1=1; exp_cnt increments each cycle.
  - exposure==0: leave on the first EXPOSE cycle.
  - Otherwise: leave when exp_cnt==exposure-1. EXPOSE lasts exactly max(exposure,1) cycles, then goes to WAIT_RDY.
- State WAIT_RDY: FSMIND1=1. f0_s=1 goes to ACK.
- State ACK:
  - FSMIND1=0, FSMIND0ACK=1.
  - Leave only when f0_s=0 and f1a_s=0 (four-phase return-to-zero).
  - If pat_idx==num_pat_latched-1, go to DONE; otherwise increment pat_idx and go to REQ.
  - FSMIND0ACK=0 on the first cycle after leaving ACK.
- State DONE: done=1 for one cycle; go to IDLE. pat_idx holds its last value until the next accepted start.
- Timeout:
  - A counter clears on entry to REQ, WAIT_RDY and ACK.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 while still waiting, go to ERR.
  - EXPOSE is never timed.
- State ERR: error=1, FSMIND1=0, FSMIND0ACK=0, busy=0. Exit only via abort or rst. start is ignored.
- abort:
  - Has priority over all transitions; next state is IDLE.
  - Clears error, FSMIND1 and FSMIND0ACK; done is not pulsed.
  - abort and start in the same cycle: abort wins and start is dropped.
- Glitches: a premature f0_s during REQ or EXPOSE is ignored; only f0_s sampled in WAIT_RDY counts. A sensor still holding FSMIND0 high from the previous pattern therefore cannot skip an exposure, because ACK requires it low first.
- Counters are CNT_W bits, unsigned, with no wrap within a legal sequence. num_pat=2^CNT_W-1 is supported.

Test Plan:
- Single pattern: num_pat=1, exposure=20, responder raises FSMIND1ACK 100 cycles after FSMIND1 and FSMIND0 200 cycles after FSMIND1, and drops both 5 cycles after FSMIND0ACK -> FSMIND1 high from start+2; EXPOSE exactly 20 cycles; FSMIND0ACK high until both inputs are low + SYNC_STAGES; done one pulse; error=0.
- Multi-pattern: num_pat=3, exposure=5 -> three full FSMIND1/FSMIND0ACK cycles; pat_idx steps 0,1,2; exactly one done pulse after the third ACK; busy high throughout.
- Zero cases: num_pat=0 -> done pulses with FSMIND1 never asserted. exposure=0, num_pat=1 -> EXPOSE lasts 1 cycle.
- Timeout: TIMEOUT_CYCLES=50, responder never raises FSMIND1ACK -> ERR entered 50 cycles after REQ entry; error=1, FSMIND1=0, busy=0. start is then ignored; abort clears error and returns to IDLE.
- Abort mid-exposure: abort asserted during EXPOSE of pattern 1 of 4 -> next cycle FSMIND1=0, busy=0, no done. A following start with num_pat=1 completes normally with pat_idx=0.
- Reset mid-operation and early FSMIND0: rst asserted asynchronously while in WAIT_RDY -> all outputs 0 immediately. FSMIND0 held high from before REQ -> no skip; the exposure count completes before ACK.

Source files
------------

// File: rtl/fsmind_handshake_ctrl.sv
// FPGA-side initiator of the imager FSMIND four-phase handshake.
// Raises FSMIND1, exposes, waits for FSMIND0, acknowledges; repeats num_pat times.
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | waiting for start
// REQ      | FSMIND1 high, waiting for synchronized FSMIND1ACK
// EXPOSE   | FSMIND1 high, counting max(exposure,1) cycles
// WAIT_RDY | FSMIND1 high, waiting for synchronized FSMIND0
// ACK      | FSMIND0ACK high, waiting for both sensor lines low
// DONE     | one-cycle completion, pulses done
// ERR      | sensor wait timed out; only abort or rst leaves
module fsmind_handshake_ctrl #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_pat,
  input  logic [CNT_W-1:0] exposure,
  input  logic             FSMIND0,
  input  logic             FSMIND1ACK,
  output logic             FSMIND1,
  output logic             FSMIND0ACK,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] pat_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_EXPOSE, S_WAIT_RDY, S_ACK, S_DONE, S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_nx;
  logic [SYNC_STAGES-1:0] f0_sync, f1a_sync;
  logic             f0_s, f1a_s;
  logic [CNT_W-1:0] exp_cnt, to_cnt, num_pat_q, exposure_q;
  logic             timed_out, exp_last, last_pat, waiting;
  logic             f1_nx, f0ack_nx, busy_nx, done_nx, err_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f0_sync  <= '0;
      f1a_sync <= '0;
    end else begin
      f0_sync  <= {f0_sync[SYNC_STAGES-2:0], FSMIND0};
      f1a_sync <= {f1a_sync[SYNC_STAGES-2:0], FSMIND1ACK};
    end
  end

  assign f0_s  = f0_sync[SYNC_STAGES-1];
  assign f1a_s = f1a_sync[SYNC_STAGES-1];

  assign waiting   = (state == S_REQ) || (state == S_WAIT_RDY) || (state == S_ACK);
  assign timed_out = (TIMEOUT_CYCLES > 0) && (to_cnt == TO_LAST);
  assign exp_last  = (exposure_q == '0) || (exp_cnt == exposure_q - ONE);
  assign last_pat  = (pat_idx == num_pat_q - ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (start && (num_pat != '0)) state_nx = S_REQ;
      S_REQ:      if (f1a_s) state_nx = S_EXPOSE;
                  else if (timed_out) state_nx = S_ERR;
      S_EXPOSE:   if (exp_last) state_nx = S_WAIT_RDY;
      S_WAIT_RDY: if (f0_s) state_nx = S_ACK;
                  else if (timed_out) state_nx = S_ERR;
      // return-to-zero: both sensor lines must drop before the next request
      S_ACK:      if (!f0_s && !f1a_s) state_nx = last_pat ? S_DONE : S_REQ;
                  else if (timed_out) state_nx = S_ERR;
      S_DONE:     state_nx = S_IDLE;
      S_ERR:      state_nx = S_ERR;
      default:    state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_cnt    <= '0;
      to_cnt     <= '0;
      num_pat_q  <= '0;
      exposure_q <= '0;
      pat_idx    <= '0;
    end else begin
      exp_cnt <= (state == S_EXPOSE) ? exp_cnt + ONE : '0;
      to_cnt  <= (waiting && (state_nx == state)) ? to_cnt + ONE : '0;
      if ((state == S_IDLE) && (state_nx == S_REQ)) begin
        num_pat_q  <= num_pat;
        exposure_q <= exposure;
        pat_idx    <= '0;
      end else if ((state == S_ACK) && (state_nx == S_REQ)) begin
        pat_idx <= pat_idx + ONE;
      end
    end
  end

  always_comb begin
    f1_nx    = 1'b0;
    f0ack_nx = 1'b0;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      S_IDLE:     done_nx = start && (num_pat == '0);
      S_REQ, S_EXPOSE, S_WAIT_RDY: begin
        f1_nx   = 1'b1;
        busy_nx = 1'b1;
      end
      S_ACK: begin
        f0ack_nx = 1'b1;
        busy_nx  = 1'b1;
      end
      S_DONE: begin
        done_nx = 1'b1;
        busy_nx = 1'b1;
      end
      S_ERR:      err_nx = 1'b1;
      default:    ;
    endcase
    // abort drops the pads in the same edge the FSM returns to IDLE
    if (abort) begin
      f1_nx    = 1'b0;
      f0ack_nx = 1'b0;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      FSMIND1    <= 1'b0;
      FSMIND0ACK <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      FSMIND1    <= f1_nx;
      FSMIND0ACK <= f0ack_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      error      <= err_nx;
    end
  end

endmodule

// File: tb/tb_fsmind_handshake_ctrl.sv
// Directed bench for fsmind_handshake_ctrl: main instance plus a short-timeout
// instance sharing the same stimulus.
module tb_fsmind_handshake_ctrl;

  localparam int CNT_W = 32;
  localparam int BOUND = 2000;

  logic             clk, rst, start, abort, FSMIND0, FSMIND1ACK;
  logic [CNT_W-1:0] num_pat, exposure;
  logic             FSMIND1, FSMIND0ACK, busy, done, error;
  logic [CNT_W-1:0] pat_idx;
  logic             to_FSMIND1, to_FSMIND0ACK, to_busy, to_done, to_error;
  logic [CNT_W-1:0] to_pat_idx;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  fsmind_handshake_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(1000), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_pat(num_pat), .exposure(exposure),
    .FSMIND0(FSMIND0), .FSMIND1ACK(FSMIND1ACK),
    .FSMIND1(FSMIND1), .FSMIND0ACK(FSMIND0ACK),
    .busy(busy), .done(done), .error(error), .pat_idx(pat_idx)
  );

  fsmind_handshake_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(50), .SYNC_STAGES(2)) dut_to (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_pat(num_pat), .exposure(exposure),
    .FSMIND0(FSMIND0), .FSMIND1ACK(FSMIND1ACK),
    .FSMIND1(to_FSMIND1), .FSMIND0ACK(to_FSMIND0ACK),
    .busy(to_busy), .done(to_done), .error(to_error), .pat_idx(to_pat_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int np, input int ex);
    num_pat  = CNT_W'(np);
    exposure = CNT_W'(ex);
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // Sensor model for one pattern; returns edge counts from the last raise to
  // FSMIND0ACK high and from the drop to FSMIND0ACK low.
  task automatic respond(input int d_ack, input int d_rdy, input int d_drop,
                         output int t_rise, output int t_fall, output int idx_rise,
                         output logic f1_rise, output logic busy_rise,
                         output logic done_fall);
    int n;
    int c;
    t_rise = -1; t_fall = -1; idx_rise = -1;
    f1_rise = 1'bx; busy_rise = 1'bx; done_fall = 1'bx;
    n = 0;
    while (!FSMIND1 && n < BOUND) begin step(); n++; end
    if (!FSMIND1) begin
      checks++; errors++;
      $display("FAIL respond_wait_fsmind1: got 0 expected 1 within %0d cycles", BOUND);
      return;
    end
    c = 0;
    while (!(FSMIND1ACK && FSMIND0)) begin
      if (c == d_ack) FSMIND1ACK = 1'b1;
      if (c == d_rdy) FSMIND0 = 1'b1;
      if (!(FSMIND1ACK && FSMIND0)) begin step(); c++; end
    end
    n = 0;
    while (!FSMIND0ACK && n < BOUND) begin step(); n++; end
    t_rise = n; idx_rise = int'(pat_idx); f1_rise = FSMIND1; busy_rise = busy;
    repeat (d_drop) step();
    FSMIND1ACK = 1'b0;
    FSMIND0    = 1'b0;
    n = 0;
    while (FSMIND0ACK && n < BOUND) begin step(); n++; end
    t_fall = n; done_fall = done;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({FSMIND1, FSMIND0ACK, busy, done, error} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 00000", {FSMIND1, FSMIND0ACK, busy, done, error});
    end
    checks++;
    if (pat_idx !== '0) begin errors++; $display("FAIL reset_pat_idx: got %0d expected 0", pat_idx); end
    checks++;
    if ({to_FSMIND1, to_busy, to_error} !== 3'b0) begin
      errors++; $display("FAIL reset_to_outputs: got %b expected 000", {to_FSMIND1, to_busy, to_error});
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int tr, tf, idx, d0;
    logic f1r, br, df;
    d0 = done_cnt;
    pulse_start(1, 20);
    checks++;
    if (FSMIND1 !== 1'b0) begin errors++; $display("FAIL single_f1_start1: got %b expected 0", FSMIND1); end
    step();
    checks++;
    if (FSMIND1 !== 1'b1) begin errors++; $display("FAIL single_f1_start2: got %b expected 1", FSMIND1); end
    respond(100, 200, 5, tr, tf, idx, f1r, br, df);
    checks++;
    if (tr !== 4) begin errors++; $display("FAIL single_ack_rise: got %0d expected 4", tr); end
    checks++;
    if (f1r !== 1'b0) begin errors++; $display("FAIL single_f1_in_ack: got %b expected 0", f1r); end
    checks++;
    if (tf !== 4) begin errors++; $display("FAIL single_ack_fall: got %0d expected 4", tf); end
    checks++;
    if (df !== 1'b1) begin errors++; $display("FAIL single_done: got %b expected 1", df); end
    repeat (3) step();
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", done_cnt - d0); end
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL single_error: got %b expected 0", error); end
  endtask

  task automatic test_multi();
    int tr, tf, idx, d0;
    logic f1r, br, df;
    d0 = done_cnt;
    pulse_start(3, 5);
    for (int i = 0; i < 3; i++) begin
      respond(3, 3, 2, tr, tf, idx, f1r, br, df);
      checks++;
      if (tr !== 10) begin errors++; $display("FAIL multi_expose_p%0d: got %0d expected 10", i, tr); end
      checks++;
      if (idx !== i) begin errors++; $display("FAIL multi_pat_idx_p%0d: got %0d expected %0d", i, idx, i); end
      checks++;
      if (br !== 1'b1) begin errors++; $display("FAIL multi_busy_p%0d: got %b expected 1", i, br); end
      checks++;
      if (df !== (i == 2)) begin errors++; $display("FAIL multi_done_p%0d: got %b expected %b", i, df, (i == 2)); end
    end
    repeat (3) step();
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL multi_done_count: got %0d expected 1", done_cnt - d0); end
    checks++;
    if (pat_idx !== 2) begin errors++; $display("FAIL multi_pat_idx_hold: got %0d expected 2", pat_idx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL multi_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_zero();
    int tr, tf, idx;
    logic f1r, br, df, seen;
    pulse_start(0, 7);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_np_done: got %b expected 1", done); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (FSMIND1 || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL zero_np_no_req: got %b expected 0", seen); end
    pulse_start(1, 0);
    respond(0, 0, 2, tr, tf, idx, f1r, br, df);
    checks++;
    if (tr !== 6) begin errors++; $display("FAIL zero_exposure: got %0d expected 6", tr); end
    checks++;
    if (df !== 1'b1) begin errors++; $display("FAIL zero_exposure_done: got %b expected 1", df); end
  endtask

  task automatic test_abort();
    int tr, tf, idx, d0, n;
    logic f1r, br, df;
    pulse_start(4, 30);
    n = 0;
    while (!FSMIND1 && n < 20) begin step(); n++; end
    FSMIND1ACK = 1'b1;
    repeat (10) step();
    d0 = done_cnt;
    abort = 1'b1;
    step();
    abort = 1'b0;
    FSMIND1ACK = 1'b0;
    checks++;
    if ({FSMIND1, busy} !== 2'b00) begin errors++; $display("FAIL abort_outputs: got %b expected 00", {FSMIND1, busy}); end
    repeat (40) step();
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL abort_no_done: got %0d expected %0d", done_cnt, d0); end
    pulse_start(1, 5);
    respond(3, 3, 2, tr, tf, idx, f1r, br, df);
    checks++;
    if (idx !== 0) begin errors++; $display("FAIL abort_restart_idx: got %0d expected 0", idx); end
    checks++;
    if (df !== 1'b1) begin errors++; $display("FAIL abort_restart_done: got %b expected 1", df); end
  endtask

  task automatic test_early_f0_and_reset();
    int tr, tf, idx, n;
    logic f1r, br, df;
    FSMIND0 = 1'b1;
    repeat (3) step();
    pulse_start(1, 20);
    n = 0;
    while (!FSMIND1 && n < 20) begin step(); n++; end
    FSMIND1ACK = 1'b1;
    n = 0;
    while (!FSMIND0ACK && n < BOUND) begin step(); n++; end
    checks++;
    if (n !== 25) begin errors++; $display("FAIL early_f0_expose: got %0d expected 25", n); end
    FSMIND1ACK = 1'b0;
    FSMIND0 = 1'b0;
    repeat (8) step();
    pulse_start(2, 3);
    respond(2, 2, 1, tr, tf, idx, f1r, br, df);
    n = 0;
    while (!FSMIND1 && n < 20) begin step(); n++; end
    FSMIND1ACK = 1'b1;
    repeat (15) step();
    checks++;
    if (pat_idx !== 1) begin errors++; $display("FAIL rst_mid_idx_before: got %0d expected 1", pat_idx); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({FSMIND1, FSMIND0ACK, busy, done, error} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got %b expected 00000", {FSMIND1, FSMIND0ACK, busy, done, error});
    end
    checks++;
    if (pat_idx !== '0) begin errors++; $display("FAIL rst_mid_idx: got %0d expected 0", pat_idx); end
    FSMIND1ACK = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int n;
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (to_error !== 1'b0) begin errors++; $display("FAIL timeout_pre_clear: got %b expected 0", to_error); end
    pulse_start(1, 5);
    n = 1;
    while (!to_error && n < 200) begin step(); n++; end
    checks++;
    if (n !== 52) begin errors++; $display("FAIL timeout_latency: got %0d expected 52", n); end
    checks++;
    if ({to_FSMIND1, to_busy, to_error} !== 3'b001) begin
      errors++; $display("FAIL timeout_outputs: got %b expected 001", {to_FSMIND1, to_busy, to_error});
    end
    pulse_start(1, 5);
    repeat (3) step();
    checks++;
    if ({to_busy, to_error} !== 2'b01) begin errors++; $display("FAIL timeout_start_ignored: got %b expected 01", {to_busy, to_error}); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (to_error !== 1'b0) begin errors++; $display("FAIL timeout_abort_clear: got %b expected 0", to_error); end
    checks++;
    if (FSMIND1 !== 1'b0) begin errors++; $display("FAIL timeout_main_abort: got %b expected 0", FSMIND1); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    FSMIND0 = 1'b0; FSMIND1ACK = 1'b0;
    num_pat = '0; exposure = '0;
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_abort();
    test_early_f0_and_reset();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
